// File: rtl/unsigned_seq_divider_if.sv
// Handshake and operand/result bundle for the unsigned sequential divider.
// The requester drives start and the operands; the divider drives status and results.
interface unsigned_seq_divider_if #(
   parameter int DW = 12,
   parameter int VW = 6
) ();
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/unsigned_seq_divider.sv
// Restoring unsigned divider: DW-bit dividend / VW-bit divisor, one quotient
// bit per clock. Results, busy and done are all registered. A zero divisor is
// answered immediately with an all-ones quotient and the dividend's low bits
// as remainder.
module unsigned_seq_divider #(
   parameter int DW = 12,
   parameter int VW = 6,
   parameter int CW = 4
) (
   input logic                clk,
   input logic                rst,
   unsigned_seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [DW-1:0] shreg_r, shreg_s;     // dividend bits out, quotient bits in
   logic [VW-1:0] dvsr_r, dvsr_s;
   logic [VW:0]   prem_r, prem_s;       // one extra bit so the compare never truncates
   logic [CW-1:0] cnt_r, cnt_s;
   logic [DW-1:0] quot_r, quot_s;
   logic [VW-1:0] rem_r, rem_s;
   logic          dbz_r, dbz_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;

   logic [VW+1:0] step_s;               // {next partial remainder, quotient bit}
   logic [VW:0]   step_prem_s;
   logic          step_qbit_s;
   logic [DW-1:0] step_shreg_s;

   // One restoring iteration: shift in the next dividend bit, subtract if it fits.
   function automatic logic [VW+1:0] restore_step(
      input logic [VW:0]   prem,
      input logic          msb,
      input logic [VW-1:0] dvsr
   );
      logic [VW:0] trial;
      trial = {prem[VW-1:0], msb};
      if (trial >= {1'b0, dvsr}) begin
         restore_step = {trial - {1'b0, dvsr}, 1'b1};
      end else begin
         restore_step = {trial, 1'b0};
      end
   endfunction

   // Datapath for the current iteration, evaluated every cycle.
   always_comb begin
      step_s       = restore_step(prem_r, shreg_r[DW-1], dvsr_r);
      step_prem_s  = step_s[VW+1:1];
      step_qbit_s  = step_s[0];
      step_shreg_s = {shreg_r[DW-2:0], step_qbit_s};
   end

   // Next-state and next-register logic for the IDLE/RUN/DONE controller.
   always_comb begin
      state_s = state_r;
      shreg_s = shreg_r;
      dvsr_s  = dvsr_r;
      prem_s  = prem_r;
      cnt_s   = cnt_r;
      quot_s  = quot_r;
      rem_s   = rem_r;
      dbz_s   = dbz_r;
      busy_s  = busy_r;
      done_s  = done_r;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               if (bus.divisor != {VW{1'b0}}) begin
                  shreg_s = bus.dividend;
                  dvsr_s  = bus.divisor;
                  prem_s  = {(VW+1){1'b0}};
                  cnt_s   = CW'(DW);
                  busy_s  = 1'b1;
                  done_s  = 1'b0;
                  state_s = ST_RUN;
               end else begin
                  quot_s  = {DW{1'b1}};
                  rem_s   = bus.dividend[VW-1:0];
                  dbz_s   = 1'b1;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  state_s = ST_DONE;
               end
            end else begin
               busy_s  = 1'b0;
               done_s  = 1'b0;
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            shreg_s = step_shreg_s;
            prem_s  = step_prem_s;
            cnt_s   = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               quot_s  = step_shreg_s;
               rem_s   = step_prem_s[VW-1:0];
               dbz_s   = 1'b0;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               state_s = ST_DONE;
            end else begin
               busy_s  = 1'b1;
               done_s  = 1'b0;
               state_s = ST_RUN;
            end
         end
         default: begin
            busy_s  = 1'b0;
            done_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and working/result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         shreg_r <= {DW{1'b0}};
         dvsr_r  <= {VW{1'b0}};
         prem_r  <= {(VW+1){1'b0}};
         cnt_r   <= {CW{1'b0}};
         quot_r  <= {DW{1'b0}};
         rem_r   <= {VW{1'b0}};
         dbz_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         shreg_r <= shreg_s;
         dvsr_r  <= dvsr_s;
         prem_r  <= prem_s;
         cnt_r   <= cnt_s;
         quot_r  <= quot_s;
         rem_r   <= rem_s;
         dbz_r   <= dbz_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quot_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;

endmodule
